inv_mix_columns_iter: RTL and testbench

//  Iterative AES-128 InvMixColumns stage for the decryption datapath; consumes the 128-bit state

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/imc_column.sv | 39 +++
 rtl/inv_mix_columns_iter.sv | 118 +++++++++++
 tb/tb_inv_mix_columns_iter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative InvMixColumns block.
// The GF products are composed from xtime chains so no lookup tables are inferred.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gmul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gmul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic byte_t gmul9(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic byte_t gmul11(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic byte_t gmul13(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic byte_t gmul14(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/imc_column.sv
// Combinational single-column mixer: inverse MixColumns by default, and forward
// MixColumns selectable through the fwd input when IMC_FORWARD_EN is defined.
module imc_column
  import aes_pkg::*;
(
  input  col_t col_in,
`ifdef IMC_FORWARD_EN
  input  logic fwd,
`endif
  output col_t col_out
);

  byte_t a0, a1, a2, a3;
  col_t  inv_col;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign inv_col = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                    gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                    gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                    gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};

`ifdef IMC_FORWARD_EN
  col_t fwd_col;

  assign fwd_col = {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
                    a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                    a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
                    gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};

  assign col_out = fwd ? fwd_col : inv_col;
`else
  assign col_out = inv_col;
`endif

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per clock through a shared mixer, valid/ready on both sides.
// Optional macro IMC_FORWARD_EN adds a fwd_mode port selecting forward MixColumns per state.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef IMC_FORWARD_EN
  input  logic         fwd_mode,
`endif
  output logic [127:0] state_out
);

  if (NCOL != 4) begin : g_ncol_check
    $error("inv_mix_columns_iter supports NCOL=4 only");
  end

  fsm_t       fsm_q, fsm_d;
  logic [1:0] col_cnt;
  state_t     work_q, work_next, result_q;
  col_t       cur_col, mixed_col;
  logic       accept, last_col;

  assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
  assign out_valid = (fsm_q == DONE);
  assign state_out = result_q;
  assign accept    = in_valid & in_ready;
  assign last_col  = (col_cnt == 2'd3);

  always_comb begin
    cur_col = work_q[127:96];
    case (col_cnt)
      2'd0:    cur_col = work_q[127:96];
      2'd1:    cur_col = work_q[95:64];
      2'd2:    cur_col = work_q[63:32];
      default: cur_col = work_q[31:0];
    endcase
  end

`ifdef IMC_FORWARD_EN
  logic mode_q;

  imc_column u_col (
    .col_in  (cur_col),
    .fwd     (mode_q),
    .col_out (mixed_col)
  );
`else
  imc_column u_col (
    .col_in  (cur_col),
    .col_out (mixed_col)
  );
`endif

  always_comb begin
    work_next = work_q;
    case (col_cnt)
      2'd0:    work_next[127:96] = mixed_col;
      2'd1:    work_next[95:64]  = mixed_col;
      2'd2:    work_next[63:32]  = mixed_col;
      default: work_next[31:0]   = mixed_col;
    endcase
  end

  // A state accepted while leaving DONE goes straight back to BUSY.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = BUSY;
      BUSY:    if (last_col) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = in_valid ? BUSY : IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      col_cnt  <= 2'd0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (accept) begin
        work_q  <= state_in;
        col_cnt <= 2'd0;
      end else if (fsm_q == BUSY) begin
        work_q <= work_next;
        if (last_col) begin
          result_q <= work_next;
        end else begin
          col_cnt <= col_cnt + 2'd1;
        end
      end else if ((fsm_q == DONE) && out_ready) begin
        col_cnt <= 2'd0;
      end
    end
  end

`ifdef IMC_FORWARD_EN
  // Mode is captured with the state so it cannot change mid-computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= fwd_mode;
    end
  end
`endif

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter against a generic GF(2^8) matrix model.
// Forward-mode scenarios are included when IMC_FORWARD_EN is defined.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
`ifdef IMC_FORWARD_EN
  logic         fwd_mode;
`endif

  int total = 0;
  int bad   = 0;
  bit fwd_sel = 1'b0;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef IMC_FORWARD_EN
    .fwd_mode  (fwd_mode),
`endif
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain shift-and-add GF(2^8) multiply and circulant matrix product
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit fwd);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (fwd) coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    else     coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(s[127-32*c-8*k -: 8], coef[(k - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one state from IDLE and takes its result; lat=-1 when no result appears.
  task automatic run_one(input logic [127:0] s, output logic [127:0] res, output int lat);
    in_valid  = 1'b1;
    state_in  = s;
    out_ready = 1'b0;
`ifdef IMC_FORWARD_EN
    fwd_mode  = fwd_sel;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    res = state_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
`ifdef IMC_FORWARD_EN
    fwd_mode  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (state_out !== 128'h0) begin bad++; $display("FAIL reset_state_out got=%h want=0", state_out); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_spec_vector();
    logic [127:0] res;
    int lat;
    fwd_sel = 1'b0;
    run_one(128'h9fdc589d_4d7ebdf8_d5d5d7d6_c6c6c6c6, res, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL vector_latency got=%0d want=4", lat); end
    total++;
    if (res !== 128'hf20a225c_2d26314c_d4d4d4d5_c6c6c6c6) begin
      bad++; $display("FAIL vector_state got=%h want=f20a225c2d26314cd4d4d4d5c6c6c6c6", res);
    end
  endtask

  task automatic test_columns();
    logic [31:0]  vin  [5] = '{32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6, 32'h01010101, 32'hc6c6c6c6};
    logic [31:0]  vout [5] = '{32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5, 32'h01010101, 32'hc6c6c6c6};
    logic [127:0] s, res, exp_s;
    int lat;
    fwd_sel = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int v = 0; v < 5; v++) begin
        s = rand_state();
        s[127-32*p -: 32] = vin[v];
        exp_s = ref_mix(s, 1'b0);
        run_one(s, res, lat);
        total++;
        if (res[127-32*p -: 32] !== vout[v]) begin
          bad++; $display("FAIL column_p%0d_v%0d got=%h want=%h", p, v, res[127-32*p -: 32], vout[v]);
        end
        total++;
        if (res !== exp_s || lat !== 4) begin
          bad++; $display("FAIL column_state_p%0d_v%0d got=%h lat=%0d want=%h lat=4", p, v, res, lat, exp_s);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s1, s2, e1, e2;
    int lat;
    bit stable;
    fwd_sel = 1'b0;
    s1 = rand_state();
    s2 = rand_state();
    e1 = ref_mix(s1, 1'b0);
    e2 = ref_mix(s2, 1'b0);
    in_valid = 1'b1; state_in = s1; out_ready = 1'b0;
`ifdef IMC_FORWARD_EN
    fwd_mode = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL bp_first_latency got=%0d want=4", lat); end
    // Offer a competing state while stalled: it must not be taken.
    in_valid = 1'b1; state_in = s2;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid !== 1'b1 || state_out !== e1 || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (!stable) begin bad++; $display("FAIL bp_hold got=unstable want=stable valid=1 out=%h ready=0", e1); end
    total++;
    if (state_out !== e1) begin bad++; $display("FAIL bp_state got=%h want=%h", state_out, e1); end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin lat = i - 1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (lat !== 4 || state_out !== e2) begin
      bad++; $display("FAIL bp_second got=%h lat=%0d want=%h lat=4", state_out, lat, e2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] s, res;
    int lat;
    bit leaked;
    fwd_sel = 1'b0;
    in_valid = 1'b1; state_in = rand_state(); out_ready = 1'b1;
`ifdef IMC_FORWARD_EN
    fwd_mode = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++;
    if (state_out !== 128'h0) begin bad++; $display("FAIL rstmid_state_out got=%h want=0", state_out); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    total++;
    if (leaked) begin bad++; $display("FAIL rstmid_no_output got=valid want=idle"); end
    out_ready = 1'b0;
    s = rand_state();
    run_one(s, res, lat);
    total++;
    if (res !== ref_mix(s, 1'b0) || lat !== 4) begin
      bad++; $display("FAIL rstmid_after got=%h lat=%0d want=%h lat=4", res, lat, ref_mix(s, 1'b0));
    end
  endtask

  task automatic test_random_stream();
    localparam int NSTATE = 1000;
    logic [127:0] q [$];
    logic [127:0] cur, exp_s;
    bit pend, cur_fwd, hs_in, hs_out;
    int sent, got, cyc;
    pend = 1'b0; cur = '0; cur_fwd = 1'b0;
    sent = 0; got = 0; cyc = 0;
    while (got < NSTATE && cyc < 40000) begin
      if (!pend && sent < NSTATE && $urandom_range(3) != 0) begin
        pend = 1'b1;
        cur  = rand_state();
`ifdef IMC_FORWARD_EN
        cur_fwd = $urandom_range(1) == 1;
`endif
      end
      in_valid  = pend;
      state_in  = cur;
      out_ready = $urandom_range(2) != 0;
`ifdef IMC_FORWARD_EN
      fwd_mode  = cur_fwd;
`endif
      #1;
      hs_in  = in_valid & in_ready;
      hs_out = out_valid & out_ready;
      if (hs_out) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra got=%h want=none", state_out);
        end else begin
          exp_s = q.pop_front();
          if (state_out !== exp_s) begin
            bad++; $display("FAIL stream_item%0d got=%h want=%h", got, state_out, exp_s);
          end
        end
        got++;
      end
      if (hs_in) begin
        q.push_back(ref_mix(cur, cur_fwd));
        pend = 1'b0;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (got !== NSTATE || q.size() != 0) begin
      bad++; $display("FAIL stream_count got=%0d left=%0d want=%0d left=0", got, q.size(), NSTATE);
    end
  endtask

`ifdef IMC_FORWARD_EN
  task automatic test_forward();
    logic [127:0] s, mid, back;
    int lat;
    for (int p = 0; p < 4; p++) begin
      s = rand_state();
      s[127-32*p -: 32] = 32'hf20a225c;
      fwd_sel = 1'b1;
      run_one(s, mid, lat);
      total++;
      if (mid[127-32*p -: 32] !== 32'h9fdc589d || mid !== ref_mix(s, 1'b1)) begin
        bad++; $display("FAIL fwd_col_p%0d got=%h want=%h", p, mid, ref_mix(s, 1'b1));
      end
    end
    for (int i = 0; i < 4; i++) begin
      s = rand_state();
      fwd_sel = 1'b1;
      run_one(s, mid, lat);
      fwd_sel = 1'b0;
      run_one(mid, back, lat);
      total++;
      if (back !== s) begin bad++; $display("FAIL fwd_roundtrip%0d got=%h want=%h", i, back, s); end
    end
    fwd_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_spec_vector();
    test_columns();
    test_backpressure();
    test_reset_mid();
`ifdef IMC_FORWARD_EN
    test_forward();
`endif
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
